// File: rtl/mem_access_unit.sv
// Byte-serial load/store unit: splits a byte/half/word access into sequential
// single-byte memory transfers and returns an extended load result.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  req_mem_wEn,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wen_q, wen_d;      // 1 = load, 0 = store
    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;  // raw little-endian load bytes
    logic [1:0]            last_k;
    logic [31:0]           ext_rdata;

    // index of the final byte for the captured size
    always_comb begin
        case (size_q)
            2'b00:   last_k = 2'd0;
            2'b01:   last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
    end

    // sign/zero extension of the assembled load bytes; stores leave rdata_q at 0
    always_comb begin
        case (size_q)
            2'b00:   ext_rdata = {{24{sign_q & rdata_q[7]}}, rdata_q[7:0]};
            2'b01:   ext_rdata = {{16{sign_q & rdata_q[15]}}, rdata_q[15:0]};
            default: ext_rdata = rdata_q;
        endcase
    end

    // next-state and output decode; memory-side outputs are zero outside ACCESS
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        size_d     = size_q;
        sign_d     = sign_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    wen_d   = req_mem_wEn;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    k_d     = 2'd0;
                    rdata_d = '0;
                    err_d   = (req_size == 2'b11);
                    state_d = (req_size == 2'b11) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_addr  = base_q + ADDR_WIDTH'(k_q);
                mem_we    = ~wen_q;
                mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
                if (mem_ack) begin
                    if (wen_q) rdata_d[{k_q, 3'b000} +: 8] = mem_rdata;
                    if (k_q == last_k) state_d = DONE;
                    else               k_d     = k_q + 2'd1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = ext_rdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and captured-request registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
